dmem_resp: RTL

- Handshaked data-memory responder: the target end of the CPU load/store path.
- Accepts one request at a time with valid/ready, inserts programmable wait states, performs a byte-strobed write or a word read, and returns a response with valid/ready.
- Sits between a future multi-cycle/pipelined cpu and the system data RAM, replacing the zero-latency dmem.

---
 rtl/dmem_pkg.sv | 32 +++
 rtl/dmem_ram_bank.sv | 31 +++
 rtl/dmem_resp.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned STRB_W     = WORD_BYTES;
    localparam int unsigned CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } dmem_req_t;

    // Access fault: misaligned, below the window, or past the last word.
    function automatic logic addr_fault(input logic [ADDR_W-1:0] addr,
                                        input logic [ADDR_W-1:0] base,
                                        input logic [ADDR_W-1:0] depth);
        logic [ADDR_W-1:0] off;
        off = addr - base;
        return (addr[1:0] != 2'b00) || (addr < base) || ((off >> 2) >= depth);
    endfunction

endpackage

// File: rtl/dmem_ram_bank.sv
// DEPTH_WORDS x 32 storage: byte-strobed synchronous write, asynchronous read.
module dmem_ram_bank
    import dmem_pkg::*;
#(
    parameter  int unsigned DEPTH_WORDS = 64,
    localparam int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  index,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < WORD_BYTES; b++) begin
                if (wstrb[b]) begin
                    mem[index][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Read returns pre-edge contents, so a load on the commit edge sees old data.
    assign rdata = mem[index];

endmodule

// File: rtl/dmem_resp.sv
// Handshaked data-memory responder with programmable wait states.
// Optional access counters when DMEM_RESP_STATS_EN is defined.
module dmem_resp
    import dmem_pkg::*;
#(
    parameter int unsigned       DEPTH_WORDS = 64,
    parameter int unsigned       WAIT_STATES = 1,
    parameter logic [ADDR_W-1:0] ADDR_BASE   = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [STRB_W-1:0] req_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
`ifdef DMEM_RESP_STATS_EN
    ,
    output logic [31:0]       stat_loads,
    output logic [31:0]       stat_stores,
    output logic [15:0]       stat_errs
`endif
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    dmem_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    dmem_req_t         req_q, req_d;
    logic              req_ready_d, rsp_valid_d, rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_d;

    dmem_req_t         in_c, cur_c;
    logic              commit_c, fault_c, ram_we_c;
    logic [IDX_W-1:0]  ram_index_c;
    logic [DATA_W-1:0] ram_rdata_c;

    // With zero wait states the access commits straight from the request port.
    always_comb begin
        in_c     = '{we: req_we, addr: req_addr, wdata: req_wdata, wstrb: req_wstrb};
        cur_c    = (state_q == IDLE) ? in_c : req_q;
        commit_c = ((state_q == IDLE) && req_valid && (WAIT_STATES == 0)) ||
                   ((state_q == WAIT) && (cnt_q == '0));
        fault_c     = addr_fault(cur_c.addr, ADDR_BASE, 32'(DEPTH_WORDS));
        ram_index_c = IDX_W'((cur_c.addr - ADDR_BASE) >> 2);
        ram_we_c    = commit_c && cur_c.we && !fault_c;
    end

    dmem_ram_bank #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we_c),
        .index(ram_index_c),
        .wdata(cur_c.wdata),
        .wstrb(cur_c.wstrb),
        .rdata(ram_rdata_c)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        req_ready_d = req_ready;
        rsp_valid_d = rsp_valid;
        rsp_rdata_d = rsp_rdata;
        rsp_err_d   = rsp_err;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    req_d       = in_c;
                    req_ready_d = 1'b0;
                    if (WAIT_STATES == 0) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(WAIT_STATES - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
                req_ready_d = 1'b1;
            end
        endcase

        if (commit_c) begin
            rsp_rdata_d = (!cur_c.we && !fault_c) ? ram_rdata_c : '0;
            rsp_err_d   = fault_c;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            req_q     <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            req_ready <= req_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
        end
    end

`ifdef DMEM_RESP_STATS_EN
    // Counters advance only on the single commit edge of each request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_loads  <= '0;
            stat_stores <= '0;
            stat_errs   <= '0;
        end else if (commit_c) begin
            if (fault_c) begin
                stat_errs <= stat_errs + 16'd1;
            end else if (cur_c.we) begin
                stat_stores <= stat_stores + 32'd1;
            end else begin
                stat_loads <= stat_loads + 32'd1;
            end
        end
    end
`endif

endmodule
